bist_controller: RTL and testbench

//  Sequences a 16-bit PRPG through PATTERN_COUNT patterns into a circuit-under-test (CUT).

---
 rtl/bist_pkg.sv | 21 ++
 rtl/bist_misr.sv | 35 +++
 rtl/bist_controller.sv | 142 ++++++++++++++
 tb/tb_bist_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and LFSR helpers for the BIST controller and its MISR.
package bist_pkg;

    localparam int unsigned WIDTH = 16;
    localparam logic [WIDTH-1:0] POLY_TAPS = 16'h0070;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_DRAIN,
        ST_COMPARE,
        ST_DONE
    } state_e;

    // Galois step for x^16+x^6+x^5+x^4+1: rotate left, fold feedback into taps 6..4.
    function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]} ^ (v[WIDTH-1] ? POLY_TAPS : '0);
    endfunction

endpackage

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register compacting CUT responses.
module bist_misr
    import bist_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] sig_out
);

    logic [WIDTH-1:0] misr_d;
    logic [WIDTH-1:0] misr_q;

    always_comb begin
        misr_d = misr_q;
        if (clear) begin
            misr_d = '0;
        end else if (enable) begin
            misr_d = galois_step(misr_q) ^ data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misr_q <= '0;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign sig_out = misr_q;

endmodule

// File: rtl/bist_controller.sv
// Logic BIST sequencer: PRPG patterns into the CUT, MISR compaction, golden compare.
module bist_controller
    import bist_pkg::*;
#(
    parameter int unsigned      PATTERN_COUNT = 1024,
    parameter int unsigned      CUT_LATENCY   = 2,
    parameter logic [WIDTH-1:0] SEED          = 16'hFFFF,
    parameter logic [WIDTH-1:0] GOLDEN_SIG    = 16'h0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    output logic             bist_mode,
    output logic [WIDTH-1:0] cut_pattern,
    output logic             cut_valid,
    input  logic [WIDTH-1:0] cut_response,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam logic [WIDTH-1:0] LAST_PAT   = WIDTH'(PATTERN_COUNT - 1);
    localparam logic [WIDTH-1:0] LAST_DRAIN = WIDTH'(CUT_LATENCY - 1);

    state_e                 state_d, state_q;
    logic [WIDTH-1:0]       prpg_d, prpg_q;
    logic [WIDTH-1:0]       cnt_d, cnt_q;
    logic [CUT_LATENCY-1:0] vpipe_d, vpipe_q;
    logic                   busy_d, busy_q;
    logic                   cut_valid_d, cut_valid_q;
    logic                   done_d, done_q;
    logic                   pass_d, pass_q;
    logic [WIDTH-1:0]       sig_d, sig_q;
    logic                   misr_clear;
    logic [WIDTH-1:0]       misr_sig;

    bist_misr u_misr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (misr_clear),
        .enable  (vpipe_q[CUT_LATENCY-1]),
        .data_in (cut_response),
        .sig_out (misr_sig)
    );

    // Next-state and datapath updates; abort overrides everything at the end.
    always_comb begin
        state_d    = state_q;
        prpg_d     = prpg_q;
        cnt_d      = cnt_q;
        vpipe_d    = CUT_LATENCY'({vpipe_q, cut_valid_q});
        pass_d     = pass_q;
        sig_d      = sig_q;
        misr_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SEED;
            end
            ST_SEED: begin
                prpg_d     = SEED;
                cnt_d      = '0;
                vpipe_d    = '0;
                misr_clear = 1'b1;
                pass_d     = 1'b0;
                sig_d      = '0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + WIDTH'(1);
                if (cnt_q == LAST_PAT) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    // Last pattern stays on cut_pattern through DRAIN.
                    prpg_d = galois_step(prpg_q);
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + WIDTH'(1);
                if (cnt_q == LAST_DRAIN) state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                sig_d   = misr_sig;
                pass_d  = (misr_sig == GOLDEN_SIG);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = start ? ST_SEED : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            vpipe_d = '0;
            pass_d  = pass_q;
            sig_d   = sig_q;
        end

        busy_d      = (state_d inside {ST_SEED, ST_RUN, ST_DRAIN, ST_COMPARE});
        cut_valid_d = (state_d == ST_RUN);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            prpg_q      <= SEED;
            cnt_q       <= '0;
            vpipe_q     <= '0;
            busy_q      <= 1'b0;
            cut_valid_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            sig_q       <= '0;
        end else begin
            state_q     <= state_d;
            prpg_q      <= prpg_d;
            cnt_q       <= cnt_d;
            vpipe_q     <= vpipe_d;
            busy_q      <= busy_d;
            cut_valid_q <= cut_valid_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            sig_q       <= sig_d;
        end
    end

    assign bist_mode   = busy_q;
    assign busy        = busy_q;
    assign cut_pattern = prpg_q;
    assign cut_valid   = cut_valid_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign signature   = sig_q;

endmodule

// File: tb/tb_bist_controller.sv
// Randomized self-checking bench for bist_controller against a sequence-level signature model.
module tb_bist_controller;

    localparam int unsigned P = 4;
    localparam int unsigned L = 2;
    localparam logic [15:0] TB_SEED   = 16'hFFFF;
    localparam logic [15:0] TB_GOLDEN = 16'h0000;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        bist_mode;
    logic [15:0] cut_pattern;
    logic        cut_valid;
    logic [15:0] cut_response;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;

    int n_checks = 0;
    int n_errors = 0;

    // CUT model: 0 = outputs constant zero, 1 = loopback of pattern XOR key, delayed L cycles.
    int          cut_mode  = 0;
    logic [15:0] key       = 16'h0000;
    int          fault_idx = -1;
    int          resp_idx  = 0;
    logic [15:0] hist  [L];
    logic        vhist [L];
    logic [15:0] pat_log [P];

    bist_controller #(
        .PATTERN_COUNT (P),
        .CUT_LATENCY   (L),
        .SEED          (TB_SEED),
        .GOLDEN_SIG    (TB_GOLDEN)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .bist_mode    (bist_mode),
        .cut_pattern  (cut_pattern),
        .cut_valid    (cut_valid),
        .cut_response (cut_response),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        hist[0]  <= cut_pattern;
        vhist[0] <= cut_valid;
        for (int i = 1; i < L; i++) begin
            hist[i]  <= hist[i-1];
            vhist[i] <= vhist[i-1];
        end
        if (!busy) resp_idx <= 0;
        else if (vhist[L-1]) resp_idx <= resp_idx + 1;
    end

    always_comb begin
        cut_response = 16'h0000;
        if (cut_mode != 0) begin
            cut_response = hist[L-1] ^ key;
            if (vhist[L-1] && resp_idx == fault_idx) cut_response = cut_response ^ 16'h0008;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] shifted;
        shifted = (v << 1) | 16'(v >> 15);
        return (v >= 16'h8000) ? (shifted ^ 16'h0070) : shifted;
    endfunction

    function automatic logic [15:0] model_pat(input int idx);
        logic [15:0] p;
        p = TB_SEED;
        for (int i = 0; i < idx; i++) p = lfsr_next(p);
        return p;
    endfunction

    function automatic logic [15:0] model_sig(input int mode, input logic [15:0] k, input int fidx);
        logic [15:0] m;
        logic [15:0] r;
        m = 16'h0000;
        for (int i = 0; i < P; i++) begin
            r = 16'h0000;
            if (mode != 0) r = model_pat(i) ^ k ^ ((i == fidx) ? 16'h0008 : 16'h0000);
            m = lfsr_next(m) ^ r;
        end
        return m;
    endfunction

    // One complete run; optional start poke mid-run (must be ignored).
    task automatic do_run(input string tag, input int poke, output logic [15:0] sig_o);
        int          n;
        int          nv;
        bit          seen;
        logic [15:0] exp_sig;
        exp_sig = model_sig(cut_mode, key, fault_idx);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_seed_busy"}, 32'(busy), 32'd1);
        n = 0; nv = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            start = (poke > 0 && n == poke);
            if (cut_valid) begin
                if (nv < P) pat_log[nv] = cut_pattern;
                nv++;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_done_cycle"}, 32'(n), 32'(P + L + 2));
        check({tag, "_nvalid"}, 32'(nv), 32'(P));
        for (int i = 0; i < P; i++) check({tag, "_pattern"}, 32'(pat_log[i]), 32'(model_pat(i)));
        check({tag, "_sig"}, 32'(signature), 32'(exp_sig));
        check({tag, "_pass"}, 32'(pass), 32'(exp_sig == TB_GOLDEN));
        sig_o = signature;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_sig_hold"}, 32'(signature), 32'(exp_sig));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s_ref;
        logic [15:0] s_tmp;
        int          n;
        int          nv;
        int          runs;
        int          dcount;
        int          done_at [2];

        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bist_mode", 32'(bist_mode), 32'd0);
        check("rst_cut_valid", 32'(cut_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_sig", 32'(signature), 32'd0);
        check("rst_pattern", 32'(cut_pattern), 32'(TB_SEED));
        reset_n = 1'b1;
        @(negedge clk);

        // Zero-response CUT: first three patterns and a zero, passing signature.
        cut_mode = 0;
        do_run("zero", 0, s_tmp);
        check("seq_p0", 32'(pat_log[0]), 32'h0000FFFF);
        check("seq_p1", 32'(pat_log[1]), 32'h0000FF8F);
        check("seq_p2", 32'(pat_log[2]), 32'h0000FF6F);
        check("zero_sig_const", 32'(s_tmp), 32'd0);

        // Loopback reference, then the same with one flipped response bit.
        cut_mode = 1; key = 16'h0000; fault_idx = -1;
        do_run("loop", 0, s_ref);
        fault_idx = 1;
        do_run("fault", 0, s_tmp);
        check("fault_differs", 32'(s_tmp != s_ref), 32'd1);
        fault_idx = -1;

        // Re-establish pass=1, then abort on the third RUN cycle.
        cut_mode = 0;
        do_run("pre_abort", 0, s_tmp);
        cut_mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0; nv = 0;
        while (nv < 3 && n < 50) begin
            @(negedge clk);
            n++;
            if (cut_valid) nv++;
        end
        check("abort_reached_run3", 32'(nv), 32'd3);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cut_valid", 32'(cut_valid), 32'd0);
        check("abort_bist_mode", 32'(bist_mode), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_sig", 32'(signature), 32'd0);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);

        // Reset dropped in DRAIN, then a full clean run.
        key = 16'h1234;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0; nv = 0;
        while (!(nv == P && !cut_valid) && n < 50) begin
            @(negedge clk);
            n++;
            if (cut_valid) nv++;
        end
        check("drain_reached_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_cut_valid", 32'(cut_valid), 32'd0);
        check("midrst_bist_mode", 32'(bist_mode), 32'd0);
        check("midrst_pattern", 32'(cut_pattern), 32'(TB_SEED));
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        do_run("post_rst", 0, s_tmp);

        // Start held high: two back-to-back runs with fresh seeding.
        key = 16'(($urandom));
        s_ref = model_sig(cut_mode, key, fault_idx);
        @(negedge clk) start = 1'b1;
        n = 0; nv = 0; runs = 0;
        while (runs < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (cut_valid) nv++;
            if (done) begin
                done_at[runs] = n;
                runs++;
                check("b2b_nvalid", 32'(nv), 32'(P));
                check("b2b_sig", 32'(signature), 32'(s_ref));
                nv = 0;
                if (runs == 2) start = 1'b0;
            end
        end
        check("b2b_runs", 32'(runs), 32'd2);
        check("b2b_done1_cycle", 32'(done_at[0]), 32'(P + L + 3));
        check("b2b_done2_cycle", 32'(done_at[1]), 32'(2 * (P + L + 3)));
        @(negedge clk);
        check("b2b_idle", 32'(busy), 32'd0);

        // Randomized runs: random CUT key, fault position, idle gaps, mid-run start pokes.
        for (int r = 0; r < 10; r++) begin
            cut_mode  = ($urandom_range(0, 3) == 0) ? 0 : 1;
            key       = 16'($urandom);
            fault_idx = int'($urandom_range(0, P)) - 1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_run("rand", int'($urandom_range(0, P + L + 1)), s_tmp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
